// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - shared types and range check for the PMA region checker
//
// Purpose: rule/attribute types, table sizing limits and the overflow-safe
// region containment check used by every rule matcher.
// Ports: none (package).

package pma_pkg;

    localparam int unsigned NrMaxRules   = 16;
    localparam int unsigned MaxAddrWidth = 64;

    // Bit order matches the packed {nonidem, cached, exec} config/response field.
    typedef struct packed {
        logic nonidem;
        logic cached;
        logic exec;
    } pma_attr_t;

    // Addresses are held zero-extended to MaxAddrWidth so narrower instances share the type.
    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] len;
        pma_attr_t               attr;
        logic                    en;
        logic                    lock;
    } pma_rule_t;

    // The end bound carries one extra bit so a region that ends exactly at the
    // top of the address space does not wrap; len=0 gives an empty region.
    function automatic logic pma_in_range(
        input logic [MaxAddrWidth-1:0] addr,
        input logic [MaxAddrWidth-1:0] base,
        input logic [MaxAddrWidth-1:0] len
    );
        logic [MaxAddrWidth:0] end_x;
        end_x = {1'b0, base} + {1'b0, len};
        return (addr >= base) && ({1'b0, addr} < end_x);
    endfunction

endpackage

// File: rtl/pma_range_match.sv
// rtl/pma_range_match.sv - combinational match of one address against one rule
//
// Purpose: asserts match_o when the rule is enabled and contains addr_i.
// Ports:
//   rule_i   one table entry
//   addr_i   zero-extended physical address
//   match_o  rule enabled and address inside [base, base+len)

module pma_range_match
    import pma_pkg::*;
(
    input  pma_rule_t               rule_i,
    input  logic [MaxAddrWidth-1:0] addr_i,
    output logic                    match_o
);

    // Attribute and lock fields do not take part in the match.
    logic unused_fields;
    assign unused_fields = ^{rule_i.attr, rule_i.lock};

    assign match_o = rule_i.en && pma_in_range(addr_i, rule_i.base, rule_i.len);

endmodule

// File: rtl/pma_region_checker.sv
// rtl/pma_region_checker.sv - runtime-programmable PMA region table with one-stage lookup
//
// Purpose: holds NrRules programmable regions and answers address lookups with
// hit / multi-hit / lowest matching rule / OR of matching attributes, one
// registered stage after a valid/ready handshake.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   cfg_we_i, cfg_idx_i, cfg_base_i,
//   cfg_len_i, cfg_attr_i, cfg_en_i,
//   cfg_lock_i                            single-entry table write
//   cfg_err_o                             one-cycle pulse when a write is rejected
//   req_valid_i, req_ready_o, req_addr_i  lookup request
//   rsp_valid_o, rsp_ready_i, rsp_hit_o,
//   rsp_multi_o, rsp_rule_o, rsp_attr_o   lookup response

module pma_region_checker
    import pma_pkg::*;
#(
    parameter int unsigned NrRules   = 8,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic [2:0]           cfg_attr_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic                 rsp_multi_o,
    output logic [IdxWidth-1:0]  rsp_rule_o,
    output logic [2:0]           rsp_attr_o
);

    pma_rule_t              table_q [NrRules];
    pma_rule_t              new_rule;
    logic [NrRules-1:0]     match;
    logic [MaxAddrWidth-1:0] addr_ext;
    logic                   wr_ok;
    logic [IdxWidth-1:0]    first_idx;
    pma_attr_t              attr_or;
    logic                   req_fire;

    assign addr_ext = MaxAddrWidth'(req_addr_i);

    always_comb begin
        new_rule      = '0;
        new_rule.base = MaxAddrWidth'(cfg_base_i);
        new_rule.len  = MaxAddrWidth'(cfg_len_i);
        new_rule.attr = pma_attr_t'(cfg_attr_i);
        new_rule.en   = cfg_en_i;
        new_rule.lock = cfg_lock_i;
    end

    // An index with no matching entry (>= NrRules) leaves wr_ok low.
    always_comb begin
        wr_ok = 1'b0;
        for (int k = 0; k < NrRules; k++) begin
            if (cfg_idx_i == IdxWidth'(k)) begin
                wr_ok = !table_q[k].lock;
            end
        end
    end

    for (genvar g = 0; g < NrRules; g++) begin : g_match
        pma_range_match u_match (
            .rule_i  (table_q[g]),
            .addr_i  (addr_ext),
            .match_o (match[g])
        );
    end

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        first_idx = '0;
        attr_or   = '0;
        for (int k = NrRules - 1; k >= 0; k--) begin
            if (match[k]) begin
                first_idx = IdxWidth'(k);
            end
        end
        for (int k = 0; k < NrRules; k++) begin
            if (match[k]) begin
                attr_or = attr_or | table_q[k].attr;
            end
        end
    end

    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;

    // Table update happens at the same edge that registers a lookup, so a
    // same-cycle lookup still sees the old entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NrRules; k++) begin
                table_q[k] <= '0;
            end
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && !wr_ok;
            if (cfg_we_i && wr_ok) begin
                for (int k = 0; k < NrRules; k++) begin
                    if (cfg_idx_i == IdxWidth'(k)) begin
                        table_q[k] <= new_rule;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_multi_o <= 1'b0;
            rsp_rule_o  <= '0;
            rsp_attr_o  <= '0;
        end else if (req_fire) begin
            rsp_valid_o <= 1'b1;
            rsp_hit_o   <= |match;
            rsp_multi_o <= $countones(match) > 1;
            rsp_rule_o  <= first_idx;
            rsp_attr_o  <= attr_or;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule
